// File: rtl/imem_load_tx.sv
// Transmit side of the imem load link: serialises one {addr, data} word into
// byte / load-clock / write-strobe phases for the chip's memory-load receiver.
module imem_load_tx #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 40,
  parameter int NUM_BYTES   = (ADDR_WIDTH + DATA_WIDTH + 7) / 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk_int,
  input  logic                  reset_n,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [ADDR_WIDTH-1:0] word_addr,
  input  logic [DATA_WIDTH-1:0] word_data,
  output logic [7:0]            load_byte,
  output logic                  load_clock,
  output logic                  load_write,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int SW = 8 * NUM_BYTES;
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int BW = $clog2(NUM_BYTES + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] CLK_HI = 3'd2;
  localparam logic [2:0] CLK_LO = 3'd3;
  localparam logic [2:0] WR_HI  = 3'd4;
  localparam logic [2:0] WR_LO  = 3'd5;

  // Fewer than 3 cycles per phase lets the receiver's 2-flop sync miss or merge edges.
  generate
    if (HOLD_CYCLES < 3) begin : g_hold_chk
      $error("imem_load_tx: HOLD_CYCLES must be at least 3");
    end
    if (SW < ADDR_WIDTH + DATA_WIDTH) begin : g_bytes_chk
      $error("imem_load_tx: NUM_BYTES too small for address plus data");
    end
  endgenerate

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [7:0]    load_byte_q, load_byte_d;
  logic          load_clock_q, load_clock_d;
  logic          load_write_q, load_write_d;
  logic          busy_q, busy_d;
  logic [15:0]   words_sent_q, words_sent_d;

  logic [SW-1:0] stream_w;
  logic          phase_done;
  logic          take_word;

  assign stream_w   = SW'({word_addr, word_data});
  assign phase_done = (state_q != IDLE) && (hold_q == HW'(HOLD_CYCLES - 1));
  // A word waiting at the end of WR_LO is taken on that same edge, so no idle gap appears.
  assign take_word  = word_valid && ((state_q == IDLE) || ((state_q == WR_LO) && phase_done));

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    load_byte_d  = load_byte_q;
    load_clock_d = load_clock_q;
    load_write_d = load_write_q;
    words_sent_d = words_sent_q;

    if (state_q != IDLE) begin
      hold_d = phase_done ? '0 : hold_q + HW'(1);
    end

    case (state_q)
      SETUP: begin
        if (phase_done) begin
          state_d      = CLK_HI;
          load_clock_d = 1'b1;
        end
      end
      CLK_HI: begin
        if (phase_done) begin
          state_d      = CLK_LO;
          load_clock_d = 1'b0;
        end
      end
      CLK_LO: begin
        if (phase_done) begin
          if (byte_idx_q == BW'(NUM_BYTES - 1)) begin
            state_d      = WR_HI;
            load_write_d = 1'b1;
          end else begin
            state_d     = SETUP;
            byte_idx_d  = byte_idx_q + BW'(1);
            load_byte_d = shift_q[SW-1 -: 8];
            shift_d     = shift_q << 8;
          end
        end
      end
      WR_HI: begin
        if (phase_done) begin
          state_d      = WR_LO;
          load_write_d = 1'b0;
        end
      end
      WR_LO: begin
        if (phase_done) begin
          state_d      = IDLE;
          words_sent_d = words_sent_q + 16'd1;
        end
      end
      default: ;
    endcase

    if (take_word) begin
      state_d     = SETUP;
      hold_d      = '0;
      byte_idx_d  = '0;
      load_byte_d = stream_w[SW-1 -: 8];
      shift_d     = stream_w << 8;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      load_byte_q  <= '0;
      load_clock_q <= 1'b0;
      load_write_q <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      load_byte_q  <= load_byte_d;
      load_clock_q <= load_clock_d;
      load_write_q <= load_write_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign word_ready = (state_q == IDLE);
  assign load_byte  = load_byte_q;
  assign load_clock = load_clock_q;
  assign load_write = load_write_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_imem_load_tx.sv
// Directed bench for imem_load_tx: byte order, strobe timing, back-to-back
// words, input isolation, async reset mid-word and counter wrap.
module tb_imem_load_tx;

  localparam int H  = 4;
  localparam int NB = 7;

  logic        clk_int = 1'b0;
  logic        reset_n = 1'b0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [9:0]  word_addr = '0;
  logic [39:0] word_data = '0;
  logic [7:0]  load_byte;
  logic        load_clock;
  logic        load_write;
  logic        busy;
  logic [15:0] words_sent;

  always #5 clk_int = ~clk_int;

  imem_load_tx #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (40),
    .NUM_BYTES  (NB),
    .HOLD_CYCLES(H)
  ) dut (
    .clk_int   (clk_int),
    .reset_n   (reset_n),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_addr (word_addr),
    .word_data (word_data),
    .load_byte (load_byte),
    .load_clock(load_clock),
    .load_write(load_write),
    .busy      (busy),
    .words_sent(words_sent)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Receiver model: shifts on each observed load_clock rise, latches on load_write rise.
  int          rise_c[$];
  int          fall_c[$];
  int          wr_r[$];
  int          wr_f[$];
  int          rdy_c[$];
  logic [7:0]  rise_b[$];
  logic [55:0] rx_words[$];
  logic [55:0] rx = '0;
  logic        lc_p = 1'b0;
  logic        lw_p = 1'b0;
  logic        rd_p = 1'b0;

  always @(negedge clk_int) begin
    cyc = cyc + 1;
    if (load_clock && !lc_p) begin
      rise_c.push_back(cyc);
      rise_b.push_back(load_byte);
      rx = {rx[47:0], load_byte};
    end
    if (!load_clock && lc_p) fall_c.push_back(cyc);
    if (load_write && !lw_p) begin
      wr_r.push_back(cyc);
      rx_words.push_back(rx);
    end
    if (!load_write && lw_p) wr_f.push_back(cyc);
    if (word_ready && !rd_p) rdy_c.push_back(cyc);
    lc_p = load_clock;
    lw_p = load_write;
    rd_p = word_ready;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    rise_c.delete();
    fall_c.delete();
    wr_r.delete();
    wr_f.delete();
    rdy_c.delete();
    rise_b.delete();
    rx_words.delete();
  endtask

  // Presents a word while idle; t0c is the negedge count just before the accept edge's effects appear.
  task automatic start_word(input logic [9:0] a, input logic [39:0] d, output int t0c);
    @(negedge clk_int);
    word_addr  = a;
    word_data  = d;
    word_valid = 1'b1;
    @(posedge clk_int);
    #1 t0c = cyc;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_byte"},  64'(load_byte),  64'h0);
    chk({tag, "_clk"},   64'(load_clock), 64'h0);
    chk({tag, "_wr"},    64'(load_write), 64'h0);
    chk({tag, "_busy"},  64'(busy),       64'h0);
    chk({tag, "_cnt"},   64'(words_sent), 64'h0);
    chk({tag, "_ready"}, 64'(word_ready), 64'h1);
  endtask

  logic [7:0]  exp_b [NB];
  logic [9:0]  a_tab [3];
  logic [39:0] d_tab [3];

  initial begin
    int t0;
    int bad;
    logic [9:0]  a_cap;
    logic [39:0] d_cap;

    exp_b = '{8'h02, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    a_tab = '{10'h3FF, 10'h001, 10'h155};
    d_tab = '{40'hFEDCBA9876, 40'h0000000001, 40'hA5A5A5A5A5};

    // Reset state
    repeat (3) @(negedge clk_int);
    check_zero_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk_int);
    chk("rel_ready", 64'(word_ready), 64'h1);
    chk("rel_busy",  64'(busy),       64'h0);

    // Single word: byte order and strobe timing
    clear_mon();
    start_word(10'h2A5, 40'h123456789A, t0);
    @(negedge clk_int);
    word_valid = 1'b0;
    repeat (93) @(negedge clk_int);
    chk("t1_rises", 64'(rise_c.size()), 64'(NB));
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("t1_byte%0d", k), 64'(rise_b[k]), 64'(exp_b[k]));
      chk($sformatf("t1_rise%0d", k), 64'(rise_c[k] - t0), 64'(1 + (3 * k + 1) * H));
      chk($sformatf("t1_fall%0d", k), 64'(fall_c[k] - t0), 64'(1 + (3 * k + 2) * H));
    end
    chk("t1_wr_rise", 64'(wr_r[0] - t0), 64'(1 + 84));
    chk("t1_wr_fall", 64'(wr_f[0] - t0), 64'(1 + 88));
    chk("t1_ready",   64'(rdy_c[0] - t0), 64'(1 + 92));
    chk("t1_count",   64'(words_sent), 64'h1);
    chk("t1_rxword",  64'(rx_words[0]), 64'h02A5123456789A);

    // Three words back-to-back with word_valid held high
    clear_mon();
    start_word(a_tab[0], d_tab[0], t0);
    @(negedge clk_int);
    word_addr = a_tab[1];
    word_data = d_tab[1];
    repeat (92) @(negedge clk_int);
    word_addr = a_tab[2];
    word_data = d_tab[2];
    repeat (92) @(negedge clk_int);
    word_valid = 1'b0;
    repeat (93) @(negedge clk_int);
    chk("t2_rises",  64'(rise_c.size()), 64'(3 * NB));
    chk("t2_nwords", 64'(rx_words.size()), 64'h3);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("t2_word%0d", w), 64'(rx_words[w]), 64'(56'({a_tab[w], d_tab[w]})));
      chk($sformatf("t2_start%0d", w), 64'(rise_c[NB * w] - t0), 64'(1 + 92 * w + H));
    end
    chk("t2_nready", 64'(rdy_c.size()), 64'h1);
    chk("t2_ready",  64'(rdy_c[0] - t0), 64'(1 + 276));
    chk("t2_count",  64'(words_sent), 64'h4);

    // Inputs scrambled every cycle during a transfer
    clear_mon();
    a_cap = 10'h0C3;
    d_cap = 40'h5A0F1E2D3C;
    start_word(a_cap, d_cap, t0);
    bad = 0;
    for (int j = 0; j < 92; j++) begin
      @(negedge clk_int);
      word_addr  = 10'($urandom);
      word_data  = 40'({$urandom, $urandom});
      word_valid = (j < 80);
      if (!busy || word_ready) bad++;
    end
    @(negedge clk_int);
    chk("t3_busy_seen",  64'(bad), 64'h0);
    chk("t3_ready_back", 64'(word_ready), 64'h1);
    chk("t3_busy_done",  64'(busy), 64'h0);
    repeat (4) @(negedge clk_int);
    chk("t3_nwords", 64'(rx_words.size()), 64'h1);
    chk("t3_rxword", 64'(rx_words[0]), 64'(56'({a_cap, d_cap})));
    chk("t3_count",  64'(words_sent), 64'h5);

    // Async reset during CLK_HI of byte 3
    clear_mon();
    start_word(10'h111, 40'h2222222222, t0);
    @(negedge clk_int);
    word_valid = 1'b0;
    repeat (41) @(negedge clk_int);
    chk("t4_in_clkhi", 64'(load_clock), 64'h1);
    chk("t4_byte3",    64'(load_byte), 64'h22);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("t4_rst");
    @(negedge clk_int);
    reset_n = 1'b1;
    @(negedge clk_int);
    clear_mon();
    start_word(10'h2BC, 40'h0123456789, t0);
    @(negedge clk_int);
    word_valid = 1'b0;
    repeat (93) @(negedge clk_int);
    chk("t4_rises",  64'(rise_c.size()), 64'(NB));
    chk("t4_first",  64'(rise_b[0]), 64'h02);
    chk("t4_rxword", 64'(rx_words[0]), 64'h02BC0123456789);
    chk("t4_count",  64'(words_sent), 64'h1);

    // Counter wrap
    @(negedge clk_int);
    force dut.words_sent_q = 16'hFFFF;
    #1 release dut.words_sent_q;
    #1 chk("t6_preset", 64'(words_sent), 64'hFFFF);
    clear_mon();
    start_word(10'h3C3, 40'hC3C3C3C3C3, t0);
    @(negedge clk_int);
    word_valid = 1'b0;
    repeat (93) @(negedge clk_int);
    chk("t6_wrap",   64'(words_sent), 64'h0);
    chk("t6_rxword", 64'(rx_words[0]), 64'(56'({10'h3C3, 40'hC3C3C3C3C3})));
    chk("t6_wrlen",  64'(wr_f[0] - wr_r[0]), 64'(H));
    chk("t6_ready",  64'(word_ready), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
